// File: rtl/div_unit.sv
// Multicycle signed divider: restoring radix-2 on magnitudes, one quotient bit
// per clock, then a sign-correction step that writes remainder (hi) and quotient (lo).
//
// state | meaning
// IDLE  | waiting for start; zero divisor raises div0 without leaving IDLE
// RUN   | WIDTH restoring iterations, one quotient bit per clock
// FIX   | apply signs, write hi/lo, pulse done
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, stateNext;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             qNeg;
  logic             rNeg;
  logic [CW-1:0]    count;

  logic             bZero;
  logic             lastIter;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   remShift;
  logic             remGeq;
  logic [WIDTH-1:0] remSub;

  assign bZero    = (b == '0);
  assign lastIter = (count == CW'(WIDTH - 1));

  // Negating the most negative value wraps to itself, which is exactly 2^(WIDTH-1)
  // when read as unsigned, so the magnitude path needs no extra bit.
  assign absA = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign absB = b[WIDTH-1] ? (~b + 1'b1) : b;

  // Extra top bit keeps the compare exact even if the shifted remainder reaches 2^WIDTH.
  assign remShift = {rem, quo[WIDTH-1]};
  assign remGeq   = (remShift >= {1'b0, divisor});
  assign remSub   = remShift[WIDTH-1:0] - divisor;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start && !bZero) stateNext = RUN;
      RUN:     if (lastIter) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == FIX);

  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      div0    <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      qNeg    <= 1'b0;
      rNeg    <= 1'b0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (bZero) begin
              div0 <= 1'b1;
            end else begin
              rem     <= '0;
              quo     <= absA;
              divisor <= absB;
              qNeg    <= a[WIDTH-1] ^ b[WIDTH-1];
              rNeg    <= a[WIDTH-1];
              count   <= '0;
            end
          end
        end
        RUN: begin
          rem   <= remGeq ? remSub : remShift[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], remGeq};
          count <= count + CW'(1);
        end
        FIX: begin
          lo   <= qNeg ? (~quo + 1'b1) : quo;
          hi   <= rNeg ? (~rem + 1'b1) : rem;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of signed divisions with hand-computed
// results, plus sequences for zero divisor, ignored restart and mid-run reset.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    string       nm;
  } vec_t;

  vec_t vecs[12];

  div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .div0  (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after an edge; leaves the bench in the done cycle (T+34).
  task automatic runDiv(input logic [31:0] ta, input logic [31:0] tb,
                        input logic [31:0] eLo, input logic [31:0] eHi, input string nm);
    int bad;
    a = ta;
    b = tb;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    bad = 0;
    for (int c = 1; c <= 33; c++) begin
      if (!(busy === 1'b1 && done === 1'b0 && div0 === 1'b0)) bad++;
      tick();
    end
    check({nm, " busy window"}, 32'(bad), 32'd0);
    check({nm, " done at T+34"}, {30'd0, done, busy}, 32'd2);
    check({nm, " lo"}, lo, eLo);
    check({nm, " hi"}, hi, eHi);
  endtask

  initial begin
    int cnt;

    vecs[0]  = '{32'd7,        32'd2,        32'd3,        32'd1,        "7/2"};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, "-7/2"};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        "7/-2"};
    vecs[3]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, "-7/-2"};
    vecs[4]  = '{32'd100,      32'd7,        32'd14,       32'd2,        "100/7"};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        "min/-1"};
    vecs[6]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        "min/1"};
    vecs[7]  = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, "max/min"};
    vecs[8]  = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        "min/min"};
    vecs[9]  = '{32'd0,        32'd5,        32'd0,        32'd0,        "0/5"};
    vecs[10] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd0,        32'hFFFFFFFF, "-1/max"};
    vecs[11] = '{32'd9,        32'd3,        32'd3,        32'd0,        "9/3"};

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset flags", {29'd0, busy, done, div0}, 32'd0);

    // Odd entries start in the done cycle of the previous one (back-to-back).
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) tick();
      runDiv(vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].nm);
    end
    tick();
    check("done single pulse", {31'd0, done}, 32'd0);

    // Zero divisor after preloading hi/lo.
    runDiv(32'd100, 32'd7, 32'd14, 32'd2, "preload");
    tick();
    a = 32'd5;
    b = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("div0 at T+1", {29'd0, div0, busy, done}, 32'd4);
    tick();
    check("div0 T+2 flags", {29'd0, div0, busy, done}, 32'd0);
    check("div0 hi held", hi, 32'd2);
    check("div0 lo held", lo, 32'd14);

    // Restart attempt mid-run is ignored.
    tick();
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 32'd55;
    b = 32'd11;
    repeat (9) tick();
    a = 32'd1;
    b = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 32'd3;
    b = 32'd3;
    repeat (23) tick();
    check("ignore done T+34", {31'd0, done}, 32'd1);
    check("ignore lo", lo, 32'd14);
    check("ignore hi", hi, 32'd2);

    // Reset during RUN discards the division.
    tick();
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset hi", hi, 32'd0);
    check("midreset lo", lo, 32'd0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) cnt++;
      tick();
    end
    check("midreset no done", 32'(cnt), 32'd0);
    runDiv(32'd9, 32'd3, 32'd3, 32'd0, "after reset 9/3");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
